// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receive controller: synchronizes rx_in, times mid-bit samples and
// delivers each byte as a one-cycle rx_valid strobe, or frame_err on a bad stop bit.
`timescale 1ns/1ps
module uart_rx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic             rx_m;
  logic             rx_s;
  logic             rx_pre;
  logic             fall;
  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       idx;
  logic [2:0]       idx_nxt;
  logic [7:0]       shreg;
  logic [7:0]       shreg_nxt;
  logic [7:0]       data_nxt;
  logic             valid_nxt;
  logic             ferr_nxt;
  logic             busy_nxt;

  // Two-flop synchronizer plus previous-value flop for edge detection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      rx_pre <= 1'b1;
    end else begin
      rx_m   <= rx_in;
      rx_s   <= rx_m;
      rx_pre <= rx_s;
    end
  end

  assign fall = !rx_s & rx_pre;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      shreg     <= shreg_nxt;
      rx_data   <= data_nxt;
      rx_valid  <= valid_nxt;
      frame_err <= ferr_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state logic; the baud counter is cleared on every transition
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    idx_nxt   = idx;
    shreg_nxt = shreg;
    data_nxt  = rx_data;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (fall) state_nxt = S_START;
      end
      S_START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          state_nxt = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt        = '0;
          shreg_nxt[idx] = rx_s;
          if (idx == 3'd7) state_nxt = S_STOP;
          else             idx_nxt   = idx + 3'd1;
        end
      end
      S_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            data_nxt  = shreg;
            valid_nxt = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_nxt = '0;
        if (rx_s) state_nxt = S_IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: frames are driven at bit-period timing and
// the receiver's strobes are compared with the byte/stop-bit outcome of each frame.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  localparam int unsigned CPB    = 16;
  localparam real         CLK_NS = 10.0;
  localparam real         BIT_NS = CPB * CLK_NS;
  localparam int          LAT    = 3 + CPB / 2 + 9 * CPB;

  logic       clock;
  logic       reset;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] vq_data[$];
  int         vq_cyc[$];
  int         fq_cyc[$];
  int         both_cnt = 0;
  int         long_cnt = 0;
  int         busy_cnt = 0;
  logic       prev_v = 1'b0;
  logic       prev_f = 1'b0;
  logic [7:0] last_good = 8'h00;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clock    (clock),
    .reset    (reset),
    .rx_in    (rx_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Strobe recorder, sampled on the falling edge
  always @(negedge clock) begin
    if (!reset) begin
      prev_v = 1'b0;
      prev_f = 1'b0;
    end else begin
      if (rx_valid) begin
        vq_data.push_back(rx_data);
        vq_cyc.push_back(cyc);
      end
      if (frame_err) fq_cyc.push_back(cyc);
      if (rx_valid && frame_err) both_cnt++;
      if ((rx_valid && prev_v) || (frame_err && prev_f)) long_cnt++;
      if (busy) busy_cnt++;
      prev_v = rx_valid;
      prev_f = frame_err;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    vq_data.delete();
    vq_cyc.delete();
    fq_cyc.delete();
    busy_cnt = 0;
  endtask

  // Drives start, 8 data bits LSB first and the stop bit; leaves the line at the stop value
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input real bit_ns);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_in = f[i];
      #(bit_ns);
    end
  endtask

  task automatic align();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_bits(input int n);
    rx_in = 1'b1;
    repeat (n * CPB) @(posedge clock);
    #1;
  endtask

  task automatic wait_not_busy(input string name);
    int k;
    k = 0;
    while (busy && k < 5000) begin
      @(negedge clock);
      k++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b expected 0 within bound", name, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    align();
    reset = 1'b1;
    idle_bits(1);
  endtask

  task automatic test_single_byte();
    int t0;
    clear_log();
    align();
    t0 = cyc;
    send_frame(8'hA5, 1'b1, BIT_NS);
    last_good = 8'hA5;
    idle_bits(2);
    wait_not_busy("single");
    checks++;
    if (vq_data.size() !== 1) begin
      errors++; $display("FAIL single_count: got %0d valid strobes expected 1", vq_data.size());
    end else begin
      checks++; if (vq_data[0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", vq_data[0]); end
      checks++; if (vq_cyc[0] - t0 !== LAT) begin errors++; $display("FAIL single_latency: got %0d expected %0d", vq_cyc[0] - t0, LAT); end
    end
    checks++; if (fq_cyc.size() !== 0) begin errors++; $display("FAIL single_ferr: got %0d expected 0", fq_cyc.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h3C;
    clear_log();
    align();
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1, BIT_NS);
    last_good = 8'h3C;
    idle_bits(2);
    wait_not_busy("b2b");
    checks++;
    if (vq_data.size() !== 3) begin
      errors++; $display("FAIL b2b_count: got %0d expected 3", vq_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (vq_data[i] !== exp[i]) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", i, vq_data[i], exp[i]); end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (vq_cyc[i] - vq_cyc[i-1] !== 10 * CPB) begin
          errors++; $display("FAIL b2b_spacing%0d: got %0d expected %0d", i, vq_cyc[i] - vq_cyc[i-1], 10 * CPB);
        end
      end
    end
    checks++; if (fq_cyc.size() !== 0) begin errors++; $display("FAIL b2b_ferr: got %0d expected 0", fq_cyc.size()); end
  endtask

  task automatic test_glitch();
    clear_log();
    align();
    rx_in = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    idle_bits(2);
    checks++; if (busy_cnt !== CPB / 2) begin errors++; $display("FAIL glitch_busy_cycles: got %0d expected %0d", busy_cnt, CPB / 2); end
    checks++; if (vq_data.size() !== 0) begin errors++; $display("FAIL glitch_valid: got %0d expected 0", vq_data.size()); end
    checks++; if (fq_cyc.size() !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d expected 0", fq_cyc.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_frame_err();
    clear_log();
    align();
    send_frame(8'h5A, 1'b0, BIT_NS);
    repeat (50) @(posedge clock);
    #1;
    idle_bits(2);
    wait_not_busy("ferr");
    checks++; if (fq_cyc.size() !== 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", fq_cyc.size()); end
    checks++; if (vq_data.size() !== 0) begin errors++; $display("FAIL ferr_valid: got %0d expected 0", vq_data.size()); end
    checks++; if (rx_data !== last_good) begin errors++; $display("FAIL ferr_hold: got %h expected %h", rx_data, last_good); end
    clear_log();
    align();
    send_frame(8'h81, 1'b1, BIT_NS);
    last_good = 8'h81;
    idle_bits(2);
    checks++;
    if (vq_data.size() !== 1) begin
      errors++; $display("FAIL ferr_next_count: got %0d expected 1", vq_data.size());
    end else begin
      checks++; if (vq_data[0] !== 8'h81) begin errors++; $display("FAIL ferr_next_data: got %h expected 81", vq_data[0]); end
    end
    checks++; if (fq_cyc.size() !== 0) begin errors++; $display("FAIL ferr_next_ferr: got %0d expected 0", fq_cyc.size()); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    b = 8'hC3;
    clear_log();
    align();
    rx_in = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 3; i++) begin
      rx_in = b[i];
      #(BIT_NS);
    end
    rx_in = b[3];
    #(BIT_NS / 2);
    reset = 1'b0;
    rx_in = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_rx_data: got %h expected 00", rx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if ({rx_valid, frame_err} !== 2'b00) begin errors++; $display("FAIL midrst_strobes: got %b expected 00", {rx_valid, frame_err}); end
    last_good = 8'h00;
    align();
    reset = 1'b1;
    idle_bits(2);
    checks++; if (vq_data.size() + fq_cyc.size() !== 0) begin errors++; $display("FAIL midrst_aborted: got %0d strobes expected 0", vq_data.size() + fq_cyc.size()); end
    align();
    send_frame(8'h12, 1'b1, BIT_NS);
    last_good = 8'h12;
    idle_bits(2);
    checks++;
    if (vq_data.size() !== 1) begin
      errors++; $display("FAIL midrst_next_count: got %0d expected 1", vq_data.size());
    end else begin
      checks++; if (vq_data[0] !== 8'h12) begin errors++; $display("FAIL midrst_next_data: got %h expected 12", vq_data[0]); end
    end
  endtask

  task automatic test_baud_tolerance();
    real scale [2];
    scale[0] = 1.03; scale[1] = 0.97;
    for (int s = 0; s < 2; s++) begin
      clear_log();
      align();
      send_frame(8'h96, 1'b1, BIT_NS * scale[s]);
      last_good = 8'h96;
      idle_bits(2);
      checks++;
      if (vq_data.size() !== 1) begin
        errors++; $display("FAIL baud%0d_count: got %0d expected 1", s, vq_data.size());
      end else begin
        checks++; if (vq_data[0] !== 8'h96) begin errors++; $display("FAIL baud%0d_data: got %h expected 96", s, vq_data[0]); end
      end
      checks++; if (fq_cyc.size() !== 0) begin errors++; $display("FAIL baud%0d_ferr: got %0d expected 0", s, fq_cyc.size()); end
    end
  endtask

  // Random frames: a frame with a high stop bit yields its byte, a low stop bit one frame_err
  task automatic test_random();
    logic [7:0] exp_q[$];
    int         exp_fe;
    logic [7:0] b;
    logic       ok;
    int         gap;
    exp_fe = 0;
    clear_log();
    for (int n = 0; n < 24; n++) begin
      b   = 8'($urandom);
      ok  = ($urandom_range(0, 4) != 0);
      gap = $urandom_range(0, 2);
      align();
      send_frame(b, ok, BIT_NS);
      rx_in = 1'b1;
      if (ok) begin
        exp_q.push_back(b);
        last_good = b;
      end else begin
        exp_fe++;
        if (gap == 0) gap = 1;
      end
      if (gap > 0) idle_bits(gap);
    end
    idle_bits(2);
    wait_not_busy("random");
    checks++;
    if (vq_data.size() !== exp_q.size()) begin
      errors++; $display("FAIL random_count: got %0d expected %0d", vq_data.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (vq_data[i] !== exp_q[i]) begin errors++; $display("FAIL random_data%0d: got %h expected %h", i, vq_data[i], exp_q[i]); end
      end
    end
    checks++; if (fq_cyc.size() !== exp_fe) begin errors++; $display("FAIL random_ferr: got %0d expected %0d", fq_cyc.size(), exp_fe); end
    checks++; if (rx_data !== last_good) begin errors++; $display("FAIL random_last: got %h expected %h", rx_data, last_good); end
  endtask

  task automatic test_strobe_rules();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d expected 0", both_cnt); end
    checks++; if (long_cnt !== 0) begin errors++; $display("FAIL strobe_width: got %0d multi-cycle strobes expected 0", long_cnt); end
  endtask

  initial begin
    reset = 1'b0;
    rx_in = 1'b1;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_midframe();
    test_baud_tolerance();
    test_random();
    test_strobe_rules();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive controller that sequences the start-edge detector, baud timing and bit sampling for the FPGA host link. It watches the serial RX pin and arms on a high-to-low transition while idle. It then times mid-bit sample points, shifts in 8 data bits LSB-first and checks the stop bit. Each completed byte goes to the command/weight loader as a one-cycle `rx_valid` strobe; stop-bit failures go out as a `frame_err` strobe.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (100 MHz / 115200); legal range ≥ 4.
- `clock`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_in`  in  1  raw asynchronous serial input; idle high.
- `rx_data`  out  8  last correctly received byte; holds until next good byte.
- `rx_valid`  out  1  one-cycle strobe, `rx_data` updated this cycle.
- `frame_err`  out  1  one-cycle strobe, stop bit sampled low.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- **Input conditioning**
  - `rx_in` passes through a 2-flop synchronizer; both flops reset to 1. The second flop's output is `rx_s`.
  - A previous-value flop `rx_pre` (reset 1) feeds the falling-edge term `fall = !rx_s & rx_pre`.
- **Counters**
  - Baud counter width is $clog2(CLKS_PER_BIT). It clears on every state entry and wraps only through state transitions.
  - Bit index is 3 bits.
- **States**
  - IDLE: counters cleared. On `fall`, go to START.
  - START: count to CLKS_PER_BIT/2 − 1 (integer divide), then sample `rx_s`.
    - 0: go to DATA.
    - 1: false start (glitch), go back to IDLE; no strobe.
  - DATA: count to CLKS_PER_BIT − 1, then sample `rx_s` into shift register bit [index] (LSB first).
    - After index 7 is sampled, go to STOP; otherwise increment index.
  - STOP: count to CLKS_PER_BIT − 1, then sample `rx_s`.
    - 1: load `rx_data` from the shift register, pulse `rx_valid`, go to IDLE.
    - 0: pulse `frame_err`, leave `rx_data` unchanged, go to BREAK.
  - BREAK: wait until `rx_s` = 1, then go to IDLE. A line held low (break) produces exactly one `frame_err`.
- **Other rules**
  - `fall` is ignored in all states except IDLE.
  - `rx_valid` and `frame_err` are never high together.
  - Reset mid-frame aborts immediately. The partial byte is discarded and no strobe is issued.

## Timing
- **Reset values:**
  - `rx_data` = 8'h00; `rx_valid` = 0; `frame_err` = 0; `busy` = 0.
  - State IDLE; sync flops and `rx_pre` = 1.
- **Detection latency:** the `rx_in` falling edge reaches `rx_s` 2 cycles later. `fall` is high in the cycle `rx_s` is first 0. START is entered on the next edge.
- **Sample point:**
  - Start-bit center is sampled CLKS_PER_BIT/2 cycles after START entry.
  - Each later sample is spaced exactly CLKS_PER_BIT cycles.
- **Strobes:**
  - `rx_valid` / `frame_err` are registered and assert the cycle after the stop-bit sample, for exactly one cycle.
  - `rx_data` changes in the same cycle `rx_valid` rises.
- **Re-arm:**
  - IDLE is entered in the same cycle as the `rx_valid` strobe. The next start edge is accepted from the cycle after that.
  - Back-to-back frames (stop bit directly followed by a start bit) are received without loss.
- `busy` is registered from state and is high from START entry through the cycle before IDLE re-entry.

## Test plan
- **Single byte:** CLKS_PER_BIT=16, send 0xA5 (8N1) → one `rx_valid` pulse with `rx_data`=0xA5, `frame_err` stays 0, `busy` returns 0.
- **Back-to-back:** send 0x00, 0xFF, 0x3C with no idle gap → three `rx_valid` pulses carrying 0x00, 0xFF, 0x3C in order, spaced 160 cycles apart.
- **Glitch rejection:** drive `rx_in` low for 4 cycles, then high → no `rx_valid`, no `frame_err`; `busy` high only until the START sample, then IDLE.
- **Frame error:** send 0x5A with stop bit 0, hold low 50 cycles, release → exactly one `frame_err` pulse; `rx_data` keeps its prior value; a following 0x81 is received correctly.
- **Reset mid-frame:** assert `reset` low during DATA bit 3 of 0xC3, release, then send 0x12 → no strobe for the aborted frame; outputs at reset values; `rx_valid` with 0x12.
- **Baud tolerance:** send 0x96 at CLKS_PER_BIT ±3% bit period → `rx_data`=0x96 with `rx_valid`, no `frame_err`.
